// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and fills the IF/ID register, with a one-entry skid for ID stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inflight_reg, inflight_next;
    logic        if_valid_reg, if_valid_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic [31:0] if_pc4_reg, if_pc4_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc4_reg, skid_pc4_next;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        fetch_done;

    assign pc_plus4   = pc_reg + 32'd4;
    assign target     = {branch_target[31:2], 2'b00};
    assign imem_req   = !rst && (state_reg != HOLD);
    // DISCARD keeps presenting the abandoned address until its ack returns.
    assign imem_addr  = (state_reg == DISCARD) ? inflight_reg : pc_reg;
    assign fetch_done = imem_req && imem_ack;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inflight_next   = inflight_reg;
        if_valid_next   = if_valid_reg;
        if_instr_next   = if_instr_reg;
        if_pc4_next     = if_pc4_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc4_next   = skid_pc4_reg;

        if (!stall) begin
            if_valid_next = 1'b0;
            if_instr_next = 32'h0;
        end

        unique case (state_reg)
            FETCH: begin
                if (branch_taken) begin
                    if_valid_next = 1'b0;
                    if_instr_next = 32'h0;
                    pc_next       = target;
                    if (!fetch_done) begin
                        inflight_next = pc_reg;
                        state_next    = DISCARD;
                    end
                end else if (fetch_done) begin
                    pc_next = pc_plus4;
                    if (!stall || !if_valid_reg) begin
                        if_valid_next = 1'b1;
                        if_instr_next = imem_rdata;
                        if_pc4_next   = pc_plus4;
                    end else begin
                        skid_instr_next = imem_rdata;
                        skid_pc4_next   = pc_plus4;
                        state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    if_valid_next   = 1'b0;
                    if_instr_next   = 32'h0;
                    skid_instr_next = 32'h0;
                    skid_pc4_next   = 32'h0;
                    pc_next         = target;
                    state_next      = FETCH;
                end else if (!stall) begin
                    if_valid_next = 1'b1;
                    if_instr_next = skid_instr_reg;
                    if_pc4_next   = skid_pc4_reg;
                    state_next    = FETCH;
                end
            end
            DISCARD: begin
                if (branch_taken) begin
                    if_valid_next = 1'b0;
                    if_instr_next = 32'h0;
                    pc_next       = target;
                end
                if (fetch_done) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC_ALIGNED;
            inflight_reg   <= RESET_PC_ALIGNED;
            if_valid_reg   <= 1'b0;
            if_instr_reg   <= 32'h0;
            if_pc4_reg     <= 32'h0;
            skid_instr_reg <= 32'h0;
            skid_pc4_reg   <= 32'h0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inflight_reg   <= inflight_next;
            if_valid_reg   <= if_valid_next;
            if_instr_reg   <= if_instr_next;
            if_pc4_reg     <= if_pc4_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc4_reg   <= skid_pc4_next;
        end
    end

    assign if_valid = if_valid_reg;
    assign if_instr = if_instr_reg;
    assign if_pc4   = if_pc4_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_opcode
            assign opcode[gi] = if_instr_reg[26 + gi];
        end
    endgenerate

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS datapath.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Writes each returned word into an IF/ID register; `opcode` feeds the main control decoder, and the rest of the word feeds the register file and sign-extend.
- Handles ID stall (one-entry skid buffer) and branch redirect (flush, plus discard of any in-flight fetch).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  ID cannot accept; IF/ID must hold its contents
branch_taken  input  1  redirect request (Branch & ALU zero); 1-cycle pulse
branch_target  input  32  redirect PC; bits [1:0] ignored and forced to 0
imem_req  output  1  fetch request outstanding
imem_addr  output  32  fetch word address (byte address, [1:0]=0)
imem_ack  input  1  1-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction
if_valid  output  1  IF/ID holds a live instruction
if_instr  output  32  IF/ID instruction; 32'h0 (NOP) when not valid
if_pc4  output  32  IF/ID PC+4 of that instruction
opcode  output  6  if_instr[31:26], to the control decoder

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; if_valid=0; if_instr=0; if_pc4=0; skid empty; state=FETCH.
  - imem_req is forced 0 while rst=1.
  - A request to RESET_PC is issued in the first cycle after rst falls.
  - rst mid-request abandons it; an ack arriving in that cycle is ignored.
- imem_req=1 in FETCH and DISCARD.
- imem_addr=pc in FETCH; it holds the in-flight address in DISCARD.
- imem_addr must stay stable while imem_req=1 until ack.
- ID consumes IF/ID on every cycle with stall=0. If no new word arrives in a consuming cycle, if_valid<=0 and if_instr<=0.
- State FETCH, on ack with branch_taken=0:
  - If stall=0 or if_valid=0: IF/ID<={rdata, pc+4}, if_valid<=1, pc<=pc+4, stay FETCH. Back-to-back requests are allowed (req stays 1, addr advances next cycle).
  - If stall=1 and if_valid=1: skid<={rdata, pc+4}, pc<=pc+4, go HOLD.
- State FETCH, no ack, branch_taken=1: pc<=target, if_valid<=0, go DISCARD. The outstanding request must still complete at the old address.
- State FETCH, ack and branch_taken=1 in the same cycle: rdata dropped, pc<=target, if_valid<=0, stay FETCH. Next request goes to the target.
- State HOLD:
  - imem_req=0.
  - When stall=0: IF/ID<=skid, if_valid<=1, go FETCH.
  - branch_taken=1 in HOLD, with any stall value: skid and IF/ID cleared, pc<=target, go FETCH.
- State DISCARD:
  - On ack: data dropped, go FETCH (pc already holds the target).
  - A further branch_taken in DISCARD overwrites pc with the newer target.
- Priority: rst > branch_taken > stall > normal.
  - branch_taken overrides stall: IF/ID is flushed even while stalled.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000 (also applies to if_pc4).
- At most one fetch outstanding. Fetch latency is ack-driven, at minimum 1 cycle (ack in the cycle the request is seen).
- opcode is purely combinational from if_instr.

Test Plan:
- Reset then straight-line fetch: RESET_PC=0, imem_ack tied 1, rdata=addr ^ 32'hA5A5_0000 -> imem_addr 0,4,8,… on consecutive cycles. if_instr follows one cycle later with if_pc4 = addr+4; if_valid=1 from cycle 2 after reset.
- Stall with skid: stall=1 for 3 cycles while ack keeps arriving -> exactly one extra word captured and req drops to 0. After stall falls, the skid word appears in IF/ID with its correct if_pc4; no word is lost or duplicated; req resumes at the next address.
- Branch during outstanding fetch: ack delayed 3 cycles, branch_taken with target 32'h0000_0100 pulsed in cycle 1 -> req stays high at the old address until ack. That data is dropped (if_valid stays 0), and the next request is to 0x100.
- Branch coincident with ack and stall: target 32'h0000_0043 -> IF/ID flushed (if_instr=0, opcode=0). The next imem_addr is 32'h0000_0040.
- PC wrap: RESET_PC=32'hFFFF_FFF8, ack tied 1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. if_pc4 for the FFFF_FFFC word is 0.
- Reset mid-request: rst asserted while req is waiting and ack arrives in the same cycle -> if_valid=0, req=0 during reset. The first request after reset is to RESET_PC.
